instr_fetch_unit: RTL and testbench

- Prefetching instruction fetch stage sitting directly upstream of riscv_core.
- Issues word reads to instruction memory over a req/gnt/rvalid bus and buffers returned words in a small FIFO.
- Delivers each instruction with its PC to the core over a valid/ready handshake.
- Flushes and restarts on redirects: jump, branch, trap vector.

---
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Core-side delivery and instruction-memory bus bundle for the IFU.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;

    // master: the fetch unit itself; slave: the core plus instruction memory
    modport master (
        input  redirect_i, redirect_pc_i, instr_ready_i,
               imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
        output instr_valid_o, instr_o, instr_pc_o, instr_err_o,
               imem_req_o, imem_addr_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, instr_ready_i,
               imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
        input  instr_valid_o, instr_o, instr_pc_o, instr_err_o,
               imem_req_o, imem_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Prefetching fetch stage with in-order response FIFO and redirect
//            flush; IFU_PERF_CNT_EN adds stall/flush counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o,
`endif
    instr_fetch_unit_if.master bus
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    // Wide enough to hold fifo_count + outstanding (up to 2*DEPTH)
    localparam int                 c_CNT_W   = c_PTR_W + 2;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [31:0]        r_fifo_data [DEPTH];
    logic [31:0]        r_fifo_pc   [DEPTH];
    logic [DEPTH-1:0]   r_fifo_err;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard_cnt;
    logic [31:0]        r_fetch_addr;
    logic [31:0]        r_resp_pc;
    logic               r_halted;

    logic [c_CNT_W-1:0] w_occupancy;
    logic [c_CNT_W-1:0] w_outstanding_nxt;
    logic [31:0]        w_redirect_pc;
    logic               w_req;
    logic               w_grant;
    logic               w_rsp;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_valid;
    logic               w_unused_pc_lsb;

    assign w_redirect_pc   = {bus.redirect_pc_i[31:2], 2'b00};
    assign w_unused_pc_lsb = ^bus.redirect_pc_i[1:0];

    // Every issued request already owns a FIFO slot, so responses never overflow
    assign w_occupancy = r_count + r_outstanding;
    assign w_req       = !reset && !bus.redirect_i && !r_halted &&
                         (r_outstanding < c_MAX_OUT) && (w_occupancy < c_DEPTH);
    assign w_grant     = w_req && bus.imem_gnt_i;
    // A response with nothing outstanding is a leftover from before reset
    assign w_rsp       = bus.imem_rvalid_i && (r_outstanding != '0);
    assign w_drop      = w_rsp && (r_discard_cnt != '0);
    assign w_push      = w_rsp && !w_drop && !bus.redirect_i;
    assign w_empty     = (r_count == '0);
    assign w_valid     = !reset && !bus.redirect_i && !w_empty;
    assign w_pop       = w_valid && bus.instr_ready_i;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_grant && !w_rsp) begin
            w_outstanding_nxt = r_outstanding + c_CNT_ONE;
        end else if (!w_grant && w_rsp) begin
            w_outstanding_nxt = r_outstanding - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_addr  <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
            r_halted      <= 1'b0;
        end else if (bus.redirect_i) begin
            // Everything still in flight belongs to the old stream
            r_fetch_addr  <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= w_outstanding_nxt;
            r_discard_cnt <= w_outstanding_nxt;
            r_halted      <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_grant) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_drop) begin
                r_discard_cnt <= r_discard_cnt - c_CNT_ONE;
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
                r_resp_pc <= r_resp_pc + 32'd4;
                if (bus.imem_err_i) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.imem_rdata_i;
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
            r_fifo_err[r_wr_ptr]  <= bus.imem_err_i;
        end
    end

    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = r_fetch_addr;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_empty ? 32'd0 : r_fifo_data[r_rd_ptr];
    assign bus.instr_pc_o    = w_empty ? 32'd0 : r_fifo_pc[r_rd_ptr];
    assign bus.instr_err_o   = w_empty ? 1'b0  : r_fifo_err[r_rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_pop && (r_count == c_DEPTH)));

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (bus.instr_ready_i && !w_valid) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (bus.redirect_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Randomized bench for instr_fetch_unit against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    instr_fetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef IFU_PERF_CNT_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .bus         (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [31:0] err_pc   = 32'h1;
    bit          rand_err_en = 1'b0;
    bit          post_rst = 1'b0;
    int          grants, valid_cnt, pops, req_after_err;
    int          first_req_cyc, first_val_cyc;
    bit          cap_first, err_seen;
    logic [31:0] first_pop_pc, err_pop_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        logic [31:0] h;
        h = mem_data(a);
        return (a == err_pc) || (rand_err_en && (h[4:0] == 5'd0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // In-order memory: a response appears once its due cycle has been reached
    task automatic drive_mem();
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_data(mq_addr[0]);
            bus.imem_err_i    = mem_err(mq_addr[0]);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
            bus.imem_err_i    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic monitor();
        int due;
        if (post_rst) begin
            chk("post_rst_valid", bus.instr_valid_o, 0);
            chk("post_rst_instr", bus.instr_o, 0);
            chk("post_rst_pc", bus.instr_pc_o, 0);
            chk("post_rst_err", bus.instr_err_o, 0);
            chk("post_rst_req", bus.imem_req_o, 1);
            chk("post_rst_addr", bus.imem_addr_o, RESET_PC);
            post_rst = 1'b0;
        end
        if (reset) begin
            chk("rst_req", bus.imem_req_o, 0);
            chk("rst_valid", bus.instr_valid_o, 0);
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end else if (bus.redirect_i) begin
            chk("redir_valid", bus.instr_valid_o, 0);
            chk("redir_req", bus.imem_req_o, 0);
            exp_pc  = {bus.redirect_pc_i[31:2], 2'b00};
            exp_req = {bus.redirect_pc_i[31:2], 2'b00};
        end else begin
            if (err_seen && bus.imem_req_o) req_after_err++;
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                chk("req_addr", bus.imem_addr_o, exp_req);
                exp_req += 32'd4;
                grants++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq_addr.push_back(bus.imem_addr_o);
                mq_due.push_back(due);
            end
            if (bus.instr_valid_o) begin
                valid_cnt++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
            end
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                chk("instr_pc", bus.instr_pc_o, exp_pc);
                chk("instr", bus.instr_o, mem_data(exp_pc));
                chk("instr_err", bus.instr_err_o, mem_err(exp_pc));
                if (cap_first) begin
                    first_pop_pc = bus.instr_pc_o;
                    cap_first    = 1'b0;
                end
                if (bus.instr_err_o) begin
                    err_seen   = 1'b1;
                    err_pop_pc = bus.instr_pc_o;
                end
                pops++;
                exp_pc += 32'd4;
            end
        end
        if (bus.imem_rvalid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
    endtask

    task automatic tick();
        drive_mem();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        int n = 0;
        bus.imem_gnt_i = 1'b0;
        bus.redirect_i = 1'b0;
        while (mq_addr.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("quiesce", mq_addr.size(), 0);
        reset = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        post_rst = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = pc;
        tick();
        bus.redirect_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hold_addr;
        reset             = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        bus.instr_ready_i = 1'b0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'd0;
        bus.imem_err_i    = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset    = 1'b0;
        post_rst = 1'b1;

        // Latency and sustained throughput with a single-cycle memory
        bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1;
        first_req_cyc = -1; first_val_cyc = -1; valid_cnt = 0;
        repeat (16) tick();
        chk("first_valid_lat", first_val_cyc - first_req_cyc, 2);
        chk("throughput", valid_cnt, 14);

        // Core stalls from reset: FIFO fills, requests stop, nothing lost
        do_reset();
        bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b0; grants = 0;
        repeat (10) tick();
        chk("stall_req_low", bus.imem_req_o, 0);
        chk("stall_valid", bus.instr_valid_o, 1);
        chk("stall_grants", grants, 4);
        bus.instr_ready_i = 1'b1;
        repeat (8) tick();

        // Grant withheld: request and address must hold
        bus.imem_gnt_i = 1'b0;
        repeat (4) tick();
        hold_addr = bus.imem_addr_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_req", bus.imem_req_o, 1);
            chk("hold_addr", bus.imem_addr_o, hold_addr);
        end
        bus.imem_gnt_i = 1'b1;
        repeat (6) tick();

        // Redirect with two responses in flight
        lat_min = 3; lat_max = 3;
        repeat (6) tick();
        redirect_to(32'h0000_0102);
        cap_first = 1'b1; pops = 0;
        repeat (12) tick();
        chk("redir_first_pc", first_pop_pc, 32'h0000_0100);
        chk("redir_progress", 32'(pops >= 3), 1);

        // Back-to-back redirects: the last one wins
        lat_min = 1; lat_max = 2;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0200; tick();
        bus.redirect_pc_i = 32'h0000_0300;
        redirect_to(32'h0000_0300);
        cap_first = 1'b1;
        repeat (10) tick();
        chk("b2b_first_pc", first_pop_pc, 32'h0000_0300);

        // Bus error at PC 0x8 halts fetching until the next redirect
        lat_min = 1; lat_max = 1;
        err_pc = 32'h0000_0008; err_seen = 1'b0; req_after_err = 0;
        redirect_to(32'h0000_0000);
        repeat (12) tick();
        chk("err_seen", 32'(err_seen), 1);
        chk("err_pc", err_pop_pc, 32'h0000_0008);
        chk("halt_req_cnt", req_after_err, 0);
        chk("halt_req", bus.imem_req_o, 0);
        err_seen = 1'b0; err_pc = 32'h1;
        redirect_to(32'h0000_0040);
        cap_first = 1'b1;
        repeat (8) tick();
        chk("resume_pc", first_pop_pc, 32'h0000_0040);

        // Randomized traffic with redirects, errors and address wrap
        lat_min = 1; lat_max = 4; rand_err_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_gnt_i    = ($urandom_range(0, 9) < 7);
            bus.instr_ready_i = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) < 4) begin
                bus.redirect_i    = 1'b1;
                bus.redirect_pc_i = ($urandom_range(0, 3) == 0) ?
                                    (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            end else begin
                bus.redirect_i = 1'b0;
            end
            tick();
        end
        bus.redirect_i = 1'b0;

        // Reset mid-stream after quiescing the bus
        bus.instr_ready_i = 1'b1;
        do_reset();
        rand_err_en = 1'b0;
        bus.imem_gnt_i = 1'b1;
        cap_first = 1'b1;
        repeat (8) tick();
        chk("post_rst_first_pc", first_pop_pc, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
